// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding / load-use hazard unit.
// Slot record carried down the result tag pipeline, the register-file select code,
// and the select-width helper.
package fwd_pkg;

  // Forward select value meaning "take the operand from the register file".
  localparam int FWD_RF = 0;

  // Widest register address a slot can carry; narrower addresses are zero-extended.
  localparam int MAX_ADDR_W = 8;

  // One result slot: what the instruction occupying it will write.
  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic [MAX_ADDR_W-1:0] rd;
    logic                  is_load;
  } slot_t;

  // Width needed to encode 0 (register file) plus slots 1..stages.
  function automatic int sel_width(input int stages);
    return (stages < 1) ? 1 : $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/fwd_tag_pipe.sv
// Result tag pipeline: STAGES-deep shift register of slot records behind EX.
// Latency: one clock per slot; slots[0] is slot1 (MEM), slots[STAGES-1] is the oldest.
// Backpressure: hold freezes every slot; a bubble enters slot1 whenever push is low.
module fwd_tag_pipe
  import fwd_pkg::*;
#(
  parameter int STAGES = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    hold,
  input  logic                    push,
  input  slot_t                   slot_in,
  output slot_t [STAGES-1:0]      slots
);

  slot_t [STAGES-1:0] slot_q;
  slot_t [STAGES-1:0] slot_d;

  // Next slot contents: shift one step unless frozen; oldest slot falls off the end.
  always_comb begin
    slot_d = slot_q;
    if (!hold) begin
      slot_d[0] = push ? slot_in : '0;
      for (int k = 1; k < STAGES; k++) begin
        slot_d[k] = slot_q[k-1];
      end
    end
  end

  // Slot registers; reset empties the whole pipeline.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slots = slot_q;

endmodule

// File: rtl/forwarding_hazard_unit.sv
// Operand bypass selection and load-use stall for EX, driven by an internal result tag pipeline.
// Latency: forward_A/forward_B/stall are combinational (zero cycles) from slots and EX inputs.
// Backpressure: stall freezes upstream and bubbles slot1; hold freezes slots and the stall counter.
module forwarding_hazard_unit
  import fwd_pkg::*;
#(
  parameter int ADDR_W     = 5,
  parameter int STAGES     = 3,
  // Lowest slot whose load data can be bypassed; valid range 1..STAGES.
  parameter int LOAD_READY = 2,
  parameter int SEL_W      = sel_width(STAGES),
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [ADDR_W-1:0] ex_rs,
  input  logic [ADDR_W-1:0] ex_rt,
  input  logic              ex_use_rs,
  input  logic              ex_use_rt,
  input  logic [ADDR_W-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_is_load,
  output logic [SEL_W-1:0]  forward_A,
  output logic [SEL_W-1:0]  forward_B,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_count
);

  slot_t [STAGES-1:0]    slots;
  slot_t                 ex_slot;
  logic                  push;
  logic [MAX_ADDR_W-1:0] rs_ext;
  logic [MAX_ADDR_W-1:0] rt_ext;
  int                    win_a;
  int                    win_b;
  logic                  win_a_load;
  logic                  win_b_load;
  logic                  haz_a;
  logic                  haz_b;
  logic [CNT_W-1:0]      stall_count_q;
  logic [CNT_W-1:0]      stall_count_d;

  // Youngest slot that will write src; win stays at the register-file code when none does.
  // Scanning oldest to youngest lets the lowest index overwrite any older match.
  function automatic void pick_youngest(
    input  slot_t [STAGES-1:0]    s,
    input  logic [MAX_ADDR_W-1:0] src,
    input  logic                  use_src,
    input  logic                  inst_valid,
    output int                    win,
    output logic                  win_load
  );
    win      = FWD_RF;
    win_load = 1'b0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (inst_valid && use_src && s[k].valid && s[k].reg_write &&
          (s[k].rd != '0) && (s[k].rd == src)) begin
        win      = k + 1;
        win_load = s[k].is_load;
      end
    end
  endfunction

  // Widen EX addresses to slot width and build the record EX would push into slot1.
  always_comb begin
    rs_ext                   = '0;
    rt_ext                   = '0;
    rs_ext[ADDR_W-1:0]       = ex_rs;
    rt_ext[ADDR_W-1:0]       = ex_rt;
    ex_slot                  = '0;
    ex_slot.valid            = 1'b1;
    ex_slot.reg_write        = ex_reg_write;
    ex_slot.rd[ADDR_W-1:0]   = ex_rd;
    ex_slot.is_load          = ex_is_load;
  end

  // Bypass selection and load-use detection; a hazarded operand falls back to the register file.
  always_comb begin
    pick_youngest(slots, rs_ext, ex_use_rs, ex_valid, win_a, win_a_load);
    pick_youngest(slots, rt_ext, ex_use_rt, ex_valid, win_b, win_b_load);
    haz_a     = win_a_load && (win_a < LOAD_READY);
    haz_b     = win_b_load && (win_b < LOAD_READY);
    stall     = haz_a || haz_b;
    forward_A = haz_a ? SEL_W'(FWD_RF) : SEL_W'(win_a);
    forward_B = haz_b ? SEL_W'(FWD_RF) : SEL_W'(win_b);
  end

  // EX reaches slot1 only when it is real, not stalled and not squashed; otherwise a bubble.
  assign push = ex_valid && !stall && !flush;

  fwd_tag_pipe #(
    .STAGES  (STAGES)
  ) u_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .hold    (hold),
    .push    (push),
    .slot_in (ex_slot),
    .slots   (slots)
  );

  // Stall cycle count: only cycles where the pipeline actually moves, pinned at all-ones.
  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && !hold && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Directed bench for forwarding_hazard_unit: main instance (LOAD_READY=2, CNT_W=16)
// plus a second instance (LOAD_READY=3, CNT_W=2) for repeated stalls and saturation.
// Inputs change 1 time unit after the rising edge; outputs are checked before the next edge.
module tb_forwarding_hazard_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       hold;
  logic       flush;
  logic       ex_valid;
  logic [4:0] ex_rs;
  logic [4:0] ex_rt;
  logic       ex_use_rs;
  logic       ex_use_rt;
  logic [4:0] ex_rd;
  logic       ex_reg_write;
  logic       ex_is_load;

  logic [1:0]  fa;
  logic [1:0]  fb;
  logic        st;
  logic [15:0] cnt;
  logic [1:0]  fa2;
  logic [1:0]  fb2;
  logic        st2;
  logic [1:0]  cnt2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  forwarding_hazard_unit dut (
    .clk          (clk),
    .reset        (reset),
    .hold         (hold),
    .flush        (flush),
    .ex_valid     (ex_valid),
    .ex_rs        (ex_rs),
    .ex_rt        (ex_rt),
    .ex_use_rs    (ex_use_rs),
    .ex_use_rt    (ex_use_rt),
    .ex_rd        (ex_rd),
    .ex_reg_write (ex_reg_write),
    .ex_is_load   (ex_is_load),
    .forward_A    (fa),
    .forward_B    (fb),
    .stall        (st),
    .stall_count  (cnt)
  );

  forwarding_hazard_unit #(
    .LOAD_READY (3),
    .CNT_W      (2)
  ) dut_lr3 (
    .clk          (clk),
    .reset        (reset),
    .hold         (hold),
    .flush        (flush),
    .ex_valid     (ex_valid),
    .ex_rs        (ex_rs),
    .ex_rt        (ex_rt),
    .ex_use_rs    (ex_use_rs),
    .ex_use_rt    (ex_use_rt),
    .ex_rd        (ex_rd),
    .ex_reg_write (ex_reg_write),
    .ex_is_load   (ex_is_load),
    .forward_A    (fa2),
    .forward_B    (fb2),
    .stall        (st2),
    .stall_count  (cnt2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one EX instruction: valid, rs, rt, use_rs, use_rt, rd, reg_write, is_load.
  task automatic ex(input logic v, input int rs, input int rt, input logic urs,
                    input logic urt, input int rd, input logic rw, input logic ld);
    ex_valid     = v;
    ex_rs        = 5'(rs);
    ex_rt        = 5'(rt);
    ex_use_rs    = urs;
    ex_use_rt    = urt;
    ex_rd        = 5'(rd);
    ex_reg_write = rw;
    ex_is_load   = ld;
    #1;
  endtask

  task automatic nop();
    ex(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b0;
    hold  = 1'b0;
    flush = 1'b0;
    nop();
    check("rst_fa_in_reset", fa, 0);
    check("rst_stall_in_reset", st, 0);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    check("rst_fa", fa, 0);
    check("rst_fb", fb, 0);
    check("rst_stall", st, 0);
    check("rst_cnt", cnt, 0);

    // ALU producer r3 aging through slots 1..3 then leaving
    ex(1, 0, 0, 0, 0, 3, 1, 0); tick();
    ex(1, 3, 0, 1, 0, 0, 0, 0); check("alu_slot1", fa, 1);
    nop(); tick();
    ex(1, 3, 0, 1, 0, 0, 0, 0); check("alu_slot2", fa, 2);
    nop(); tick();
    ex(1, 3, 0, 1, 0, 0, 0, 0); check("alu_slot3", fa, 3);
    nop(); tick();
    ex(1, 3, 0, 1, 0, 0, 0, 0); check("alu_gone", fa, 0);

    // lw r5 then dependent on rt: one stall cycle, then bypass from slot2
    ex(1, 0, 0, 0, 0, 5, 1, 1); tick();
    ex(1, 0, 5, 0, 1, 6, 1, 0);
    check("lu_stall", st, 1);
    check("lu_fb_forced_rf", fb, 0);
    tick();
    check("lu_stall_clear", st, 0);
    check("lu_fb_slot2", fb, 2);
    check("lu_cnt", cnt, 1);
    nop(); tick();

    // two producers of r7: youngest (slot1) wins on both operands
    ex(1, 0, 0, 0, 0, 7, 1, 0); tick(); tick();
    ex(1, 7, 7, 1, 1, 0, 0, 0);
    check("young_fa", fa, 1);
    check("young_fb", fb, 1);
    check("young_stall", st, 0);

    // register 0 never forwarded even from a load; unused or invalid sources ignored
    ex(1, 0, 0, 0, 0, 0, 1, 1); tick();
    ex(1, 0, 0, 1, 1, 0, 0, 0);
    check("r0_fa", fa, 0);
    check("r0_stall", st, 0);
    ex(1, 0, 0, 0, 0, 9, 1, 0); tick();
    ex(1, 9, 0, 0, 0, 0, 0, 0); check("unused_rs_fa", fa, 0);
    ex(0, 9, 0, 1, 0, 0, 0, 0); check("invalid_ex_fa", fa, 0);
    ex(1, 9, 0, 1, 0, 0, 0, 0); check("used_rs_fa", fa, 1);

    // load hazard frozen by hold for 4 cycles
    ex(1, 0, 0, 0, 0, 5, 1, 1); tick();
    ex(1, 0, 5, 0, 1, 6, 1, 0);
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("hold_stall", st, 1);
      check("hold_cnt", cnt, 1);
    end
    hold = 1'b0;
    tick();
    check("hold_cnt_after", cnt, 2);
    check("hold_stall_after", st, 0);
    check("hold_fb_after", fb, 2);
    nop(); tick();

    // flush together with stall: bubble inserted, stall still reported
    ex(1, 0, 0, 0, 0, 5, 1, 1); tick();
    flush = 1'b1;
    ex(1, 0, 5, 0, 1, 8, 1, 0);
    check("flush_stall", st, 1);
    tick();
    flush = 1'b0;
    #1;
    check("flush_stall_clear", st, 0);
    check("flush_fb", fb, 2);
    check("flush_cnt", cnt, 3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    ex(1, 8, 0, 1, 0, 0, 0, 0);
    check("flush_dropped", fa, 0);

    // asynchronous reset in the middle of a stall
    nop(); tick();
    ex(1, 0, 0, 0, 0, 5, 1, 1); tick();
    ex(1, 0, 5, 0, 1, 6, 1, 0);
    check("arst_pre_stall", st, 1);
    reset = 1'b0;
    #1;
    check("arst_stall", st, 0);
    check("arst_fb", fb, 0);
    check("arst_cnt", cnt, 0);
    nop(); tick();
    reset = 1'b1;
    #1;

    // LOAD_READY=3 instance: two stall cycles then slot3 bypass; 2-bit counter saturates
    ex(1, 0, 0, 0, 0, 5, 1, 1); tick();
    ex(1, 0, 5, 0, 1, 6, 1, 0);
    check("lr3_stall_c1", st2, 1);
    check("lr3_fb_c1", fb2, 0);
    tick();
    check("lr3_stall_c2", st2, 1);
    tick();
    check("lr3_stall_done", st2, 0);
    check("lr3_fb_slot3", fb2, 3);
    check("lr3_cnt", cnt2, 2);
    tick();
    ex(1, 0, 0, 0, 0, 5, 1, 1); tick();
    ex(1, 0, 5, 0, 1, 6, 1, 0); tick(); tick();
    check("sat_cnt_max", cnt2, 3);
    nop(); tick();
    ex(1, 0, 0, 0, 0, 5, 1, 1); tick();
    ex(1, 0, 5, 0, 1, 6, 1, 0);
    check("sat_stall", st2, 1);
    tick(); tick();
    check("sat_no_wrap", cnt2, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
